// File: rtl/cmd_seq_pkg.sv
// Shared types and helpers for the command sequencer: FSM state encoding,
// stage-mask search functions and the default dwell counter width.
package cmd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Widest stage mask the helper functions accept; callers zero-extend.
  localparam int MAX_STAGES        = 32;
  localparam int DEFAULT_STAGE_LEN = 16;
  // Dwell counter width for the default stage length (counts 0..STAGE_LEN-1).
  localparam int STAGE_CNT_W       = $clog2(DEFAULT_STAGE_LEN);

  // Index of the lowest set mask bit strictly above cur; -1 when none.
  // Pass cur = -1 to find the lowest enabled stage overall.
  function automatic int next_enabled(input logic [MAX_STAGES-1:0] mask, input int cur);
    int res;
    res = -1;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (i > cur && mask[i]) res = i;
    end
    return res;
  endfunction

  // Number of enabled stages in a mask.
  function automatic int popcount(input logic [MAX_STAGES-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/cmd_deser.sv
// Serial-to-parallel command deserialiser, MSB first. word/word_valid are
// presented combinationally on the edge that captures the final bit so the
// sequencer can register the accepted command on that same edge.
module cmd_deser #(
  parameter int CMD_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             strobe_in,
  output logic [CMD_W-1:0] word,
  output logic             word_valid
);

  localparam int CW = $clog2(CMD_W + 1);

  logic [CMD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Shift in one bit per strobe; the count wraps to 0 when a word completes.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word       = (shift_q << 1) | CMD_W'(data_in);
    word_valid = 1'b0;
    if (strobe_in) begin
      shift_d = word;
      if (cnt_q == CW'(CMD_W - 1)) begin
        word_valid = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Shift register and bit count; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: accepts deserialised command words under a busy/overrun
// policy and plays a masked one-hot stage sequence, each enabled stage held
// for STAGE_LEN cycles, with a saturating cycle counter since the last run.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int CMD_W      = 8,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_LEN  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  strobe_in,
  output logic [CMD_W-1:0]      cmd_type,
  output logic                  cmd_valid,
  output logic [CNT_W-1:0]      clk_cnt,
  output logic [NUM_STAGES-1:0] stage,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int DWELL_W = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [CMD_W-1:0] word;
  logic             word_valid;

  cmd_deser #(.CMD_W(CMD_W)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .strobe_in  (strobe_in),
    .word       (word),
    .word_valid (word_valid)
  );

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [CMD_W-1:0]      cmd_type_q, cmd_type_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  logic [NUM_STAGES-1:0] word_mask;
  logic [MAX_STAGES-1:0] word_ext, run_ext;
  int                    first_stage, next_stage;

  // Acceptance policy, stage progression and counters. A word arriving on
  // the final expiry edge is judged against RUN: zero mask aborts (and wins
  // over done), non-zero mask is dropped while done still fires.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    cmd_type_d  = cmd_type_q;
    cmd_valid_d = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    clk_cnt_d   = (clk_cnt_q == {CNT_W{1'b1}}) ? clk_cnt_q : clk_cnt_q + CNT_W'(1);

    word_mask = word[NUM_STAGES-1:0];
    word_ext  = '0;
    word_ext[NUM_STAGES-1:0] = word_mask;
    run_ext   = '0;
    run_ext[NUM_STAGES-1:0]  = mask_q;
    first_stage = next_enabled(word_ext, -1);
    next_stage  = next_enabled(run_ext, int'(idx_q));

    case (state_q)
      IDLE: begin
        if (word_valid) begin
          cmd_type_d  = word;
          cmd_valid_d = 1'b1;
          if (word_mask != '0) begin
            state_d   = RUN;
            mask_d    = word_mask;
            idx_d     = IW'(first_stage);
            dwell_d   = '0;
            clk_cnt_d = '0;
          end
        end
      end
      RUN: begin
        if (dwell_q == DWELL_W'(STAGE_LEN - 1)) begin
          if (next_stage < 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = IW'(next_stage);
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
        if (word_valid) begin
          if (word_mask == '0) begin
            cmd_type_d  = word;
            cmd_valid_d = 1'b1;
            state_d     = IDLE;
            done_d      = 1'b0;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      dwell_q     <= '0;
      cmd_type_q  <= '0;
      cmd_valid_q <= 1'b0;
      clk_cnt_q   <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      cmd_type_q  <= cmd_type_d;
      cmd_valid_q <= cmd_valid_d;
      clk_cnt_q   <= clk_cnt_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // One-hot stage decode from registered state only.
  always_comb begin
    stage = '0;
    if (state_q == RUN) stage = NUM_STAGES'(1) << idx_q;
  end

  assign busy      = (state_q == RUN);
  assign cmd_type  = cmd_type_q;
  assign cmd_valid = cmd_valid_q;
  assign clk_cnt   = clk_cnt_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
